lr_return_stack: RTL and testbench
==================================

Name: lr_return_stack

Overview:
- Parametrised successor to the single-register link-back detector.
- Watches the execute stage for the return trigger: an LD whose source register value equals MAGIC_ADDR.
- Keeps a circular return-address stack filled by calls and popped by returns, so nested calls return correctly.
- Issues a registered ready/valid redirect to fetch and stalls upstream while the redirect is pending.

Parameters:
ADDR_W, 16, width of addresses and register values
DEPTH, 8, return-stack entries (power of two, >=2)
MAGIC_ADDR, 16'hFFFF, source value that marks an LD as a return trigger

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  pipeline flush; cancels pending redirect and same-cycle call/trigger
call_valid_i  in  1  call instruction in execute this cycle
call_ret_addr_i  in  ADDR_W  return address to push
ld_valid_i  in  1  LD instruction in execute this cycle
ld_src_val_i  in  ADDR_W  forwarded source register value of that LD
lr_i  in  ADDR_W  architectural LR, used as fallback on an empty stack
clr_flags_i  in  1  clears the sticky flags
redirect_ready_i  in  1  fetch accepts the redirect
redirect_valid_o  out  1  redirect pending
redirect_addr_o  out  ADDR_W  target address, stable while valid
link_back_o  out  1  one-cycle pulse on the first cycle of each redirect
stall_o  out  1  upstream must hold execute
depth_o  out  $clog2(DEPTH+1)  number of valid entries
overflow_o  out  1  sticky: a push overwrote the oldest entry
underflow_o  out  1  sticky: a return hit an empty stack

Behaviour:
- Reset (async, rst_i=1): state IDLE; every output 0; depth 0; top pointer 0; stack contents don't-care.
- trigger = ld_valid_i & (ld_src_val_i == MAGIC_ADDR), full ADDR_W compare. A trigger is accepted only in IDLE with flush_i=0.
- FSM states:
  - IDLE: on an accepted trigger, go to REDIRECT next cycle.
    - Load redirect_addr_o with the top entry; if depth==0, load lr_i instead and set underflow_o.
    - Pop: depth-1, saturating at 0.
  - REDIRECT: redirect_valid_o=1 and stall_o=1.
    - link_back_o=1 only on the first REDIRECT cycle.
    - Return to IDLE on redirect_ready_i=1 (transfer occurs that cycle) or on flush_i=1.
- Latency: trigger in cycle N -> redirect_valid_o and link_back_o in N+1. If ready is already high, the FSM is back in IDLE at N+2.
- Triggers while in REDIRECT are not accepted and have no effect on the stack; the upstream holds them via stall_o.
- Calls while in REDIRECT are also blocked by stall_o and ignored.
- Push (call_valid_i=1, IDLE, flush_i=0): write call_ret_addr_i at top+1 and advance top, wrapping mod DEPTH.
  - If depth==DEPTH, the oldest entry is overwritten, depth stays DEPTH and overflow_o is set.
- Call and trigger in the same cycle: pop first, then push.
  - Redirect target is the old top (or lr_i if empty, setting underflow_o).
  - The new address replaces that slot.
  - Net depth: unchanged if the stack was non-empty; 1 if it was empty.
- flush_i=1:
  - Drops a pending redirect at the clock edge: no transfer, no link_back_o in later cycles.
  - Suppresses same-cycle call/trigger.
  - Stack contents and depth are untouched.
- Reset mid-REDIRECT: immediate return to IDLE; outputs 0 asynchronously.
- Sticky flags: set as above, cleared by clr_flags_i. If set and clear occur in the same cycle, set wins.
- redirect_addr_o is registered and does not change while redirect_valid_o=1.

Test Plan:
- Reset, then ld_valid_i=1 with ld_src_val_i=FFFF and lr_i=0x1234 on an empty stack -> next cycle redirect_valid_o=1, addr=0x1234, link_back_o pulse, underflow_o=1, depth_o=0.
- Push 0x0100, 0x0200, 0x0300, then three triggers with ready=1 -> redirects 0x0300, 0x0200, 0x0100 in order; depth 3->0; no flags set.
- Push 9 addresses 0x10..0x18 with DEPTH=8 -> overflow_o=1, depth_o=8; eight triggers return 0x18 down to 0x11; a ninth returns lr_i and sets underflow_o.
- Trigger with redirect_ready_i held 0 for 4 cycles -> valid, addr and stall_o stay 1 for 4 cycles; link_back_o high only in the first cycle; a second trigger during this window leaves depth unchanged.
- Stack holds [0x40,0x50]; same-cycle call 0x60 and trigger -> redirect 0x50, depth stays 2; the next trigger returns 0x60.
- Pending redirect, flush_i=1 -> valid drops the next cycle with no transfer; depth unchanged. ld_src_val_i=0xFFFE -> never triggers.

Source files
------------

// File: rtl/lr_return_stack_if.sv
// Redirect handshake between the return stack (master) and fetch (slave).
interface lr_return_stack_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              redirect_ready;

    modport master (output redirect_valid, output redirect_addr, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_addr, output redirect_ready);
endinterface

// File: rtl/lr_return_stack.sv
// Return-address stack: calls push, magic-address LD triggers pop and a
// registered redirect to fetch, with upstream stall while it is pending.
module lr_return_stack #(
    parameter int unsigned       ADDR_W     = 16,
    parameter int unsigned       DEPTH      = 8,
    parameter logic [ADDR_W-1:0] MAGIC_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       call_valid_i,
    input  logic [ADDR_W-1:0]          call_ret_addr_i,
    input  logic                       ld_valid_i,
    input  logic [ADDR_W-1:0]          ld_src_val_i,
    input  logic [ADDR_W-1:0]          lr_i,
    input  logic                       clr_flags_i,
    lr_return_stack_if.master          redir,
    output logic                       link_back_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH+1)-1:0] depth_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, REDIRECT} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                link_back_q, link_back_d;
    logic [PTR_W-1:0]    top_q, top_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [ADDR_W-1:0]   stack_q [DEPTH];

    logic                trigger_c;
    logic                push_en_c;
    logic [PTR_W-1:0]    wr_ptr_c;
    logic [PTR_W-1:0]    pop_top_c;
    logic [DEPTH_W-1:0]  pop_depth_c;

    assign trigger_c = ld_valid_i && (ld_src_val_i == MAGIC_ADDR);

    // Next-state: pop (if triggered) is applied before push, so a same-cycle
    // call overwrites the slot just returned from.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        link_back_d = 1'b0;
        top_d       = top_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q & ~clr_flags_i;
        underflow_d = underflow_q & ~clr_flags_i;
        push_en_c   = 1'b0;
        wr_ptr_c    = top_q;
        pop_top_c   = top_q;
        pop_depth_c = depth_q;

        case (state_q)
            IDLE: begin
                if (!flush_i) begin
                    if (trigger_c) begin
                        state_d     = REDIRECT;
                        link_back_d = 1'b1;
                        if (depth_q == DEPTH_W'(0)) begin
                            addr_d      = lr_i;
                            underflow_d = 1'b1;
                        end else begin
                            addr_d      = stack_q[top_q];
                            pop_top_c   = top_q - PTR_W'(1);
                            pop_depth_c = depth_q - DEPTH_W'(1);
                        end
                    end
                    top_d   = pop_top_c;
                    depth_d = pop_depth_c;
                    if (call_valid_i) begin
                        push_en_c = 1'b1;
                        wr_ptr_c  = pop_top_c + PTR_W'(1);
                        top_d     = wr_ptr_c;
                        if (pop_depth_c == DEPTH_W'(DEPTH)) begin
                            overflow_d = 1'b1;
                        end else begin
                            depth_d = pop_depth_c + DEPTH_W'(1);
                        end
                    end
                end
            end
            REDIRECT: begin
                if (redir.redirect_ready || flush_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            link_back_q <= 1'b0;
            top_q       <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            link_back_q <= link_back_d;
            top_q       <= top_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack storage needs no reset; depth_q qualifies every read.
    always_ff @(posedge clk_i) begin
        if (push_en_c) begin
            stack_q[wr_ptr_c] <= call_ret_addr_i;
        end
    end

    assign redir.redirect_valid = (state_q == REDIRECT);
    assign redir.redirect_addr  = addr_q;
    assign stall_o              = (state_q == REDIRECT);
    assign link_back_o          = link_back_q;
    assign depth_o              = depth_q;
    assign overflow_o           = overflow_q;
    assign underflow_o          = underflow_q;
endmodule

// File: tb/tb_lr_return_stack.sv
// Bench for lr_return_stack: directed vector table, async reset check, and
// randomized traffic against a queue-based reference model.
module tb_lr_return_stack;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 8;
    localparam logic [15:0] F      = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i, call_valid_i, ld_valid_i, clr_flags_i;
    logic [15:0] call_ret_addr_i, ld_src_val_i, lr_i;
    logic        link_back_o, stall_o, overflow_o, underflow_o;
    logic [3:0]  depth_o;

    lr_return_stack_if #(.ADDR_W(ADDR_W)) rif ();

    lr_return_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC_ADDR(16'hFFFF)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .call_valid_i(call_valid_i), .call_ret_addr_i(call_ret_addr_i),
        .ld_valid_i(ld_valid_i), .ld_src_val_i(ld_src_val_i), .lr_i(lr_i),
        .clr_flags_i(clr_flags_i), .redir(rif),
        .link_back_o(link_back_o), .stall_o(stall_o), .depth_o(depth_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        call; logic [15:0] caddr;
        logic        ld;   logic [15:0] src; logic [15:0] lr;
        logic        rdy, flush, clr;
        logic        e_v;  logic [15:0] e_addr; logic e_lb;
        int          e_depth; logic e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic call, input logic [15:0] ca,
                                input logic ld, input logic [15:0] src, input logic [15:0] lr,
                                input logic rdy, input logic fl, input logic clr,
                                input logic ev, input logic [15:0] ea, input logic elb,
                                input int ed, input logic eo, input logic eu);
        vec_t v;
        v.call = call; v.caddr = ca; v.ld = ld; v.src = src; v.lr = lr;
        v.rdy = rdy; v.flush = fl; v.clr = clr;
        v.e_v = ev; v.e_addr = ea; v.e_lb = elb; v.e_depth = ed; v.e_ovf = eo; v.e_unf = eu;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic call, input logic [15:0] ca, input logic ld,
                         input logic [15:0] src, input logic [15:0] lr,
                         input logic rdy, input logic fl, input logic clr);
        call_valid_i = call; call_ret_addr_i = ca; ld_valid_i = ld; ld_src_val_i = src;
        lr_i = lr; rif.redirect_ready = rdy; flush_i = fl; clr_flags_i = clr;
    endtask

    // Reference model: a queue whose back is the top of stack.
    logic [15:0] m_stk[$];
    bit          m_pend, m_lb, m_ovf, m_unf;
    logic [15:0] m_addr;

    task automatic model_reset();
        m_stk.delete(); m_pend = 0; m_lb = 0; m_ovf = 0; m_unf = 0; m_addr = '0;
    endtask

    task automatic model_step(input logic call, input logic [15:0] ca, input logic ld,
                              input logic [15:0] src, input logic [15:0] lr,
                              input logic rdy, input logic fl, input logic clr);
        bit ovs = 0, uns = 0;
        m_lb = 0;
        if (m_pend) begin
            if (rdy || fl) m_pend = 0;
        end else if (!fl) begin
            if (ld && src == 16'hFFFF) begin
                if (m_stk.size() > 0) m_addr = m_stk.pop_back();
                else begin m_addr = lr; uns = 1; end
                m_pend = 1; m_lb = 1;
            end
            if (call) begin
                if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); ovs = 1; end
                m_stk.push_back(ca);
            end
        end
        if (clr) begin m_ovf = 0; m_unf = 0; end
        if (ovs) m_ovf = 1;
        if (uns) m_unf = 1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        #12 rst_i = 1'b0;
        #1;
        chk("reset_valid", 0, 32'(rif.redirect_valid), 0);
        chk("reset_addr",  0, 32'(rif.redirect_addr), 0);
        chk("reset_lb",    0, 32'(link_back_o), 0);
        chk("reset_stall", 0, 32'(stall_o), 0);
        chk("reset_depth", 0, 32'(depth_o), 0);
        chk("reset_flags", 0, {30'd0, overflow_o, underflow_o}, 0);

        // Directed table: empty-stack return, LIFO order, same-cycle call+return,
        // ready held low, flush, near-magic value, overflow/underflow, set-wins-clear.
        add(0,0,      1,F,16'h1234, 0,0,0,  1,16'h1234,1, 0,0,1);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       0,0,1);
        add(0,0,      0,0,0,        0,0,1,  0,0,0,       0,0,0);
        add(1,16'h100,0,0,0,        0,0,0,  0,0,0,       1,0,0);
        add(1,16'h200,0,0,0,        0,0,0,  0,0,0,       2,0,0);
        add(1,16'h300,0,0,0,        0,0,0,  0,0,0,       3,0,0);
        add(0,0,      1,F,0,        1,0,0,  1,16'h300,1, 2,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       2,0,0);
        add(0,0,      1,F,0,        1,0,0,  1,16'h200,1, 1,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       1,0,0);
        add(0,0,      1,F,0,        1,0,0,  1,16'h100,1, 0,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       0,0,0);
        add(1,16'h40, 0,0,0,        0,0,0,  0,0,0,       1,0,0);
        add(1,16'h50, 0,0,0,        0,0,0,  0,0,0,       2,0,0);
        add(1,16'h60, 1,F,0,        1,0,0,  1,16'h50,1,  2,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       2,0,0);
        add(0,0,      1,F,0,        1,0,0,  1,16'h60,1,  1,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       1,0,0);
        add(1,16'h70, 0,0,0,        0,0,0,  0,0,0,       2,0,0);
        add(1,16'h80, 0,0,0,        0,0,0,  0,0,0,       3,0,0);
        add(0,0,      1,F,0,        0,0,0,  1,16'h80,1,  2,0,0);
        add(0,0,      1,F,0,        0,0,0,  1,16'h80,0,  2,0,0);
        add(1,16'h90, 0,0,0,        0,0,0,  1,16'h80,0,  2,0,0);
        add(0,0,      0,0,0,        0,0,0,  1,16'h80,0,  2,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       2,0,0);
        add(0,0,      1,F,0,        0,0,0,  1,16'h70,1,  1,0,0);
        add(0,0,      0,0,0,        0,1,0,  0,0,0,       1,0,0);
        add(1,16'hAA, 1,F,0,        0,1,0,  0,0,0,       1,0,0);
        add(0,0,      1,16'hFFFE,0, 1,0,0,  0,0,0,       1,0,0);
        add(0,0,      1,F,0,        1,0,0,  1,16'h40,1,  0,0,0);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,       0,0,0);
        for (int i = 0; i < 9; i++)
            add(1,16'(16'h10 + i), 0,0,0, 0,0,0, 0,0,0, (i < 8) ? i + 1 : 8, (i == 8), 0);
        for (int k = 0; k < 8; k++) begin
            add(0,0, 1,F,0, 1,0,0, 1,16'(16'h18 - k),1, 7 - k,1,0);
            add(0,0, 0,0,0, 1,0,0, 0,0,0,             7 - k,1,0);
        end
        add(0,0,      1,F,16'hBEEF, 1,0,0,  1,16'hBEEF,1, 0,1,1);
        add(0,0,      0,0,0,        1,0,0,  0,0,0,        0,1,1);
        add(0,0,      1,F,16'h1111, 1,0,1,  1,16'h1111,1, 0,0,1);
        add(0,0,      0,0,0,        1,0,1,  0,0,0,        0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].call, vecs[i].caddr, vecs[i].ld, vecs[i].src, vecs[i].lr,
                  vecs[i].rdy, vecs[i].flush, vecs[i].clr);
            @(posedge clk); #1;
            chk("valid", i, 32'(rif.redirect_valid), 32'(vecs[i].e_v));
            if (vecs[i].e_v) chk("addr", i, 32'(rif.redirect_addr), 32'(vecs[i].e_addr));
            chk("link_back", i, 32'(link_back_o), 32'(vecs[i].e_lb));
            chk("stall", i, 32'(stall_o), 32'(vecs[i].e_v));
            chk("depth", i, 32'(depth_o), 32'(vecs[i].e_depth));
            chk("overflow", i, 32'(overflow_o), 32'(vecs[i].e_ovf));
            chk("underflow", i, 32'(underflow_o), 32'(vecs[i].e_unf));
        end

        // Async reset while a redirect is pending: outputs clear before any edge.
        drive(1, 16'h77, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 1, F, 16'h5555, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_valid", 0, 32'(rif.redirect_valid), 1);
        chk("pre_rst_addr",  0, 32'(rif.redirect_addr), 32'h77);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_valid", 0, 32'(rif.redirect_valid), 0);
        chk("rst_stall", 0, 32'(stall_o), 0);
        chk("rst_lb",    0, 32'(link_back_o), 0);
        chk("rst_depth", 0, 32'(depth_o), 0);
        #1 rst_i = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic        r_call, r_ld, r_rdy, r_fl, r_clr;
            logic [15:0] r_ca, r_src, r_lr;
            r_call = ($urandom_range(0, 9) < 4);
            r_ca   = 16'($urandom);
            r_ld   = ($urandom_range(0, 9) < 3);
            r_src  = ($urandom_range(0, 9) < 7) ? F : (($urandom_range(0, 1) == 1) ? 16'hFFFE : 16'($urandom));
            r_lr   = 16'($urandom);
            r_rdy  = ($urandom_range(0, 1) == 1);
            r_fl   = ($urandom_range(0, 19) == 0);
            r_clr  = ($urandom_range(0, 19) == 0);
            model_step(r_call, r_ca, r_ld, r_src, r_lr, r_rdy, r_fl, r_clr);
            drive(r_call, r_ca, r_ld, r_src, r_lr, r_rdy, r_fl, r_clr);
            @(posedge clk); #1;
            chk("rnd_valid", c, 32'(rif.redirect_valid), 32'(m_pend));
            if (m_pend) chk("rnd_addr", c, 32'(rif.redirect_addr), 32'(m_addr));
            chk("rnd_link_back", c, 32'(link_back_o), 32'(m_lb));
            chk("rnd_stall", c, 32'(stall_o), 32'(m_pend));
            chk("rnd_depth", c, 32'(depth_o), 32'(m_stk.size()));
            chk("rnd_overflow", c, 32'(overflow_o), 32'(m_ovf));
            chk("rnd_underflow", c, 32'(underflow_o), 32'(m_unf));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
